// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions.
//   XLEN      - address width
//   RESET_PC  - fetch address loaded by reset
//   TRAP_VEC  - fetch address taken on a misaligned jump target
//   PC_INC    - sequential fetch stride in bytes
//   pcr_state_t - pc_redirect controller states
package rv32_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } pcr_state_t;

endpackage

// File: rtl/pc_redirect_flush_timer.sv
// flush_timer: loadable 2-bit down-counter that times the wrong-path bubble
// window after a redirect.
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   load  - load `depth` (has priority over counting)
//   en    - count enable; low while the pipeline is frozen
//   depth - reload value (1..3)
//   done  - the current cycle is the last bubble (count == 1)
module flush_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [1:0] depth,
  output logic       done
);

  logic [1:0] bcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
    end else if (load) begin
      bcnt <= depth;
    end else if (en && bcnt != '0) begin
      bcnt <= bcnt - 2'd1;
    end
  end

  assign done = (bcnt == 2'd1);

endmodule

// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC controller. Redirects fetch on a taken branch/jump
// from EX, flushes IF/ID and ID/EX, and masks wrong-path fetches for
// FLUSH_DEPTH cycles. Misaligned targets trap to TRAP_VEC.
//   clk, rst      - clock, synchronous active-high reset
//   jump_flag     - taken transfer resolved in EX
//   jump_target   - destination of the transfer
//   stall         - ID hazard stall, holds pc
//   mem_stall     - whole-pipeline freeze
//   pc            - fetch address
//   if_valid      - fetched instruction is on the correct path
//   flush_ifid    - clear IF/ID on next edge
//   flush_idex    - clear ID/EX on next edge
//   misalign      - one-cycle pulse after a trapped misaligned target
//   redirect_cnt  - accepted redirects, wrapping
module pc_redirect #(
  parameter int unsigned          XLEN        = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC    = rv32_pkg::RESET_PC,
  parameter logic [XLEN-1:0]      TRAP_VEC    = rv32_pkg::TRAP_VEC,
  parameter int unsigned          FLUSH_DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            mem_stall,
  output logic [XLEN-1:0] pc,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign,
  output logic [31:0]     redirect_cnt
);

  import rv32_pkg::*;

  localparam logic [1:0] DEPTH = FLUSH_DEPTH[1:0];

  pcr_state_t      state;
  logic            accept;
  logic            redirect;
  logic            target_bad;
  logic            done;
  logic [XLEN-1:0] pc_next_seq;

  assign accept      = jump_flag & ~mem_stall;
  assign flush_ifid  = accept & ~rst;
  assign flush_idex  = accept & ~rst;
  assign redirect    = accept && (state != BOOT);
  assign target_bad  = (jump_target[1:0] != 2'b00);
  assign pc_next_seq = pc + XLEN'(PC_INC);
  assign if_valid    = (state == RUN) & ~mem_stall;

  flush_timer u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (redirect),
    .en    (~mem_stall),
    .depth (DEPTH),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= BOOT;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      misalign <= 1'b0;
      if (!mem_stall) begin
        case (state)
          BOOT: state <= RUN;
          RUN, FLUSH: begin
            // The jump in EX is older than the ID hazard, so it beats stall.
            if (accept) begin
              pc           <= target_bad ? TRAP_VEC : jump_target;
              misalign     <= target_bad;
              redirect_cnt <= redirect_cnt + 32'd1;
              state        <= FLUSH;
            end else begin
              if (!stall) pc <= pc_next_seq;
              if (state == FLUSH && done) state <= RUN;
            end
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule
